// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a uart_tx: circular buffer plus a drain FSM that hands one
// byte at a time to the transmitter and waits out its busy handshake.
module uart_tx_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   input  logic          clr_ovf,
   input  logic          tx_busy,
   output logic          tx_send,
   output logic [7:0]    tx_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          overflow
);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] wptr_r, rptr_r;
   logic [AW:0]   count_r, count_nxt_s;
   logic          full_r, empty_r, ovf_r, tx_send_r;
   logic [7:0]    tx_data_r;
   logic [1:0]    wait_cnt_r, wait_cnt_nxt_s;
   state_t        state_r, state_nxt_s;
   logic          pop_s, push_s, drop_s;

   // Drain FSM next-state; pop_s marks the IDLE cycle that loads a byte.
   always_comb begin
      state_nxt_s    = state_r;
      wait_cnt_nxt_s = wait_cnt_r;
      pop_s          = 1'b0;
      case (state_r)
         IDLE: begin
            if (!empty_r && !tx_busy) begin
               pop_s       = 1'b1;
               state_nxt_s = SEND;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SEND: begin
            wait_cnt_nxt_s = 2'd0;
            state_nxt_s    = WAIT_HI;
         end
         WAIT_HI: begin
            // Give up after four cycles without busy; the byte is not re-sent.
            if (tx_busy) begin
               wait_cnt_nxt_s = 2'd0;
               state_nxt_s    = WAIT_LO;
            end else if (wait_cnt_r == 2'd3) begin
               wait_cnt_nxt_s = 2'd0;
               state_nxt_s    = IDLE;
            end else begin
               wait_cnt_nxt_s = wait_cnt_r + 2'd1;
            end
         end
         WAIT_LO: begin
            if (!tx_busy) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = WAIT_LO;
            end
         end
         default: begin
            state_nxt_s    = IDLE;
            wait_cnt_nxt_s = 2'd0;
         end
      endcase
   end

   // Write acceptance and occupancy; a pop frees the slot a full-FIFO write needs.
   always_comb begin
      push_s = wr_en && (!full_r || pop_s);
      drop_s = wr_en && !push_s;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
   end

   // Storage array, intentionally without reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wptr_r] <= wr_data;
      end
   end

   // Pointers, flags, FSM state and registered transmitter outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_r     <= '0;
         rptr_r     <= '0;
         count_r    <= '0;
         full_r     <= 1'b0;
         empty_r    <= 1'b1;
         ovf_r      <= 1'b0;
         tx_send_r  <= 1'b0;
         tx_data_r  <= 8'h00;
         wait_cnt_r <= 2'd0;
         state_r    <= IDLE;
      end else begin
         if (push_s) begin
            wptr_r <= wptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rptr_r    <= rptr_r + PTR_ONE;
            tx_data_r <= mem_r[rptr_r];
         end
         count_r <= count_nxt_s;
         full_r  <= (count_nxt_s == FULL_CNT);
         empty_r <= (count_nxt_s == '0);
         // A drop in the same cycle as clr_ovf wins.
         if (drop_s) begin
            ovf_r <= 1'b1;
         end else if (clr_ovf) begin
            ovf_r <= 1'b0;
         end
         tx_send_r  <= (state_nxt_s == SEND);
         wait_cnt_r <= wait_cnt_nxt_s;
         state_r    <= state_nxt_s;
      end
   end

   assign tx_send  = tx_send_r;
   assign tx_data  = tx_data_r;
   assign full     = full_r;
   assign empty    = empty_r;
   assign count    = count_r;
   assign overflow = ovf_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple uart_tx busy model.
module tb_uart_tx_fifo;

   localparam int BUSY_CYC = 10;

   logic       clk;
   logic       rst_n;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       clr_ovf;
   logic       tx_send;
   logic [7:0] tx_data;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       overflow;
   logic       force_busy;
   logic       model_busy;
   logic       model_en;
   logic       tx_busy;

   int         tests_run;
   int         tests_failed;
   int         cyc;
   int         last_pulse;
   int         spacing_viol;
   int         bcnt;
   logic [7:0] rx_q [$];

   assign tx_busy = model_busy | force_busy;

   uart_tx_fifo #(.DEPTH(16), .AW(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .clr_ovf  (clr_ovf),
      .tx_busy  (tx_busy),
      .tx_send  (tx_send),
      .tx_data  (tx_data),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // uart_tx model: busy rises the negedge it sees tx_send, stays high BUSY_CYC cycles.
   always @(negedge clk) begin
      if (!model_en) begin
         model_busy = 1'b0;
         bcnt       = 0;
      end else if (tx_send) begin
         model_busy = 1'b1;
         bcnt       = BUSY_CYC;
      end else if (bcnt > 0) begin
         bcnt = bcnt - 1;
         if (bcnt == 0) model_busy = 1'b0;
      end
   end

   // Transmit monitor: collect bytes and check pulse spacing.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (tx_send === 1'b1) begin
         if (cyc - last_pulse < 3) spacing_viol = spacing_viol + 1;
         last_pulse = cyc;
         rx_q.push_back(tx_data);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run = tests_run + 1;
      if (got !== exp) begin
         tests_failed = tests_failed + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_rx(input int n, input int budget);
      int k = 0;
      while (rx_q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check_eq("rx_timeout", 32'(rx_q.size() >= n), 32'd1);
   endtask

   task automatic fill(input logic [7:0] base);
      for (int i = 0; i < 16; i++) begin
         wr_en   = 1'b1;
         wr_data = base + 8'(i);
         @(negedge clk);
      end
      wr_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tests_run = 0; tests_failed = 0; cyc = 0; last_pulse = -100; spacing_viol = 0;
      bcnt = 0; model_busy = 1'b0; model_en = 1'b1; force_busy = 1'b0;
      rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check_eq("rst_count", count, 0);
      check_eq("rst_empty", empty, 1);
      check_eq("rst_full", full, 0);
      check_eq("rst_ovf", overflow, 0);
      check_eq("rst_send", tx_send, 0);
      check_eq("rst_data", tx_data, 8'h00);
      rst_n = 1'b1;

      // Single byte
      @(negedge clk);
      wr_en = 1'b1; wr_data = 8'hA5;
      @(negedge clk);
      wr_en = 1'b0;
      check_eq("sb_count1", count, 1);
      check_eq("sb_empty0", empty, 0);
      check_eq("sb_nosend", tx_send, 0);
      @(negedge clk);
      check_eq("sb_send", tx_send, 1);
      check_eq("sb_data", tx_data, 8'hA5);
      check_eq("sb_empty1", empty, 1);
      @(negedge clk);
      check_eq("sb_pulse1", tx_send, 0);
      check_eq("sb_hold", tx_data, 8'hA5);
      repeat (20) @(negedge clk);
      check_eq("sb_npulse", rx_q.size(), 1);
      check_eq("sb_rx", rx_q[0], 8'hA5);

      // Burst of 16 with busy held until full
      rx_q.delete();
      force_busy = 1'b1;
      fill(8'h01);
      check_eq("bu_count", count, 16);
      check_eq("bu_full", full, 1);
      check_eq("bu_ovf", overflow, 0);
      force_busy = 1'b0;
      wait_rx(16, 600);
      repeat (20) @(negedge clk);
      check_eq("bu_npulse", rx_q.size(), 16);
      for (int i = 0; i < 16; i++) check_eq("bu_order", rx_q[i], 8'(i + 1));
      check_eq("bu_count0", count, 0);
      check_eq("bu_empty", empty, 1);
      check_eq("bu_full0", full, 0);

      // Overflow and clr_ovf priority
      rx_q.delete();
      force_busy = 1'b1;
      fill(8'h20);
      wr_en = 1'b1; wr_data = 8'hFF;
      @(negedge clk);
      wr_en = 1'b0;
      check_eq("ov_flag", overflow, 1);
      check_eq("ov_count", count, 16);
      wr_en = 1'b1; wr_data = 8'hFE; clr_ovf = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      check_eq("ov_clr_drop", overflow, 1);
      @(negedge clk);
      clr_ovf = 1'b0;
      check_eq("ov_clr", overflow, 0);
      force_busy = 1'b0;
      wait_rx(16, 600);
      repeat (30) @(negedge clk);
      check_eq("ov_npulse", rx_q.size(), 16);
      for (int i = 0; i < 16; i++) check_eq("ov_order", rx_q[i], 8'h20 + 8'(i));

      // Write during the pop cycle of a full FIFO
      rx_q.delete();
      force_busy = 1'b1;
      fill(8'h40);
      check_eq("sw_full_pre", full, 1);
      force_busy = 1'b0; wr_en = 1'b1; wr_data = 8'h55;
      @(negedge clk);
      wr_en = 1'b0;
      check_eq("sw_count", count, 16);
      check_eq("sw_full", full, 1);
      check_eq("sw_send", tx_send, 1);
      check_eq("sw_data", tx_data, 8'h40);
      check_eq("sw_ovf", overflow, 0);
      wait_rx(17, 700);
      repeat (20) @(negedge clk);
      check_eq("sw_npulse", rx_q.size(), 17);
      for (int i = 0; i < 16; i++) check_eq("sw_order", rx_q[i], 8'h40 + 8'(i));
      check_eq("sw_last", rx_q[16], 8'h55);

      // Busy timeout: four WAIT_HI cycles, then a queued byte goes out
      rx_q.delete();
      model_en = 1'b0;
      wr_en = 1'b1; wr_data = 8'h3C;
      @(negedge clk);
      wr_en = 1'b0;
      @(negedge clk);
      check_eq("to_send", tx_send, 1);
      check_eq("to_data", tx_data, 8'h3C);
      @(negedge clk);
      wr_en = 1'b1; wr_data = 8'h3D;
      check_eq("to_gap3", tx_send, 0);
      @(negedge clk);
      wr_en = 1'b0;
      for (int k = 4; k < 8; k++) begin
         check_eq("to_gap", tx_send, 0);
         @(negedge clk);
      end
      check_eq("to_send2", tx_send, 1);
      check_eq("to_data2", tx_data, 8'h3D);
      repeat (20) @(negedge clk);
      check_eq("to_norepeat", rx_q.size(), 2);
      model_en = 1'b1;

      // Reset during WAIT_LO with five bytes queued
      rx_q.delete();
      force_busy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wr_en = 1'b1; wr_data = 8'h60 + 8'(i);
         @(negedge clk);
      end
      wr_en = 1'b0;
      force_busy = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rm_count5", count, 5);
      rst_n = 1'b0;
      #1;
      check_eq("rm_count0", count, 0);
      check_eq("rm_send0", tx_send, 0);
      check_eq("rm_empty", empty, 1);
      check_eq("rm_data0", tx_data, 8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check_eq("rm_nosend", rx_q.size(), 1);
      check_eq("rm_count", count, 0);

      // Write in the first cycle after reset release
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
      @(negedge clk);
      wr_en = 1'b0;
      check_eq("fw_count", count, 1);
      wait_rx(2, 100);
      check_eq("fw_data", rx_q[1], 8'h77);

      check_eq("spacing", spacing_viol, 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
